// File: rtl/siso_shift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// siso_ctrl_pkg
// Shared types and constants for the SISO shift-chain controller.
//   state_t     : controller FSM states (IDLE, LOAD, DRAIN, DONE)
//   PAR_BITS    : extra bits shifted after the data word (1 when the
//                 SISO_CTRL_PARITY_EN macro is defined, else 0)
//   cnt_width() : width of the global shift-cycle counter
//   idx_width() : width of a bit index into the data word
// ---------------------------------------------------------------------------
package siso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef SISO_CTRL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // The counter walks global shift cycles 0 .. N+DEPTH-1, N = width + parity.
  function automatic int cnt_width(input int width, input int depth);
    int total;
    total = width + PAR_BITS + depth;
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_if.sv
// ---------------------------------------------------------------------------
// siso_shift_ctrl_if
// Bundles the word-side handshakes, the shift-chain control and status.
// Macro: SISO_CTRL_PARITY_EN adds the out_err status signal.
//
// Handshake rule (both in_* and out_* channels): a transfer happens on a
// rising edge where valid and ready are both 1. Once valid is raised the
// producer holds valid and data steady until that transfer; ready may be
// high without valid and carries no obligation.
//
//   in_data/in_valid/in_ready    : word into the controller
//   out_data/out_valid/out_ready : reassembled word out of the controller
//   sh_en/sh_si                  : shift enable / serial data into chain
//   sh_so                        : serial data from the last chain stage
//   busy                         : controller not in IDLE
//   out_err                      : parity mismatch (parity build only)
//
// modport slave  : the controller
// modport master : word source/sink plus the chain
// ---------------------------------------------------------------------------
interface siso_shift_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sh_en;
  logic             sh_si;
  logic             sh_so;
  logic             busy;
`ifdef SISO_CTRL_PARITY_EN
  logic             out_err;

  modport slave (
    input  in_data, in_valid, out_ready, sh_so,
    output in_ready, out_data, out_valid, sh_en, sh_si, busy, out_err
  );
  modport master (
    output in_data, in_valid, out_ready, sh_so,
    input  in_ready, out_data, out_valid, sh_en, sh_si, busy, out_err
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready, sh_so,
    output in_ready, out_data, out_valid, sh_en, sh_si, busy
  );
  modport master (
    output in_data, in_valid, out_ready, sh_so,
    input  in_ready, out_data, out_valid, sh_en, sh_si, busy
  );
`endif
endinterface

// File: rtl/siso_shift_ctrl_deser.sv
// ---------------------------------------------------------------------------
// siso_deser
// Capture register that rebuilds the parallel word from the chain output.
// One bit is written per enabled cycle at the index supplied by the
// controller; unwritten bits keep their value.
//   clk, rst : clock, synchronous active-high reset (clears the word)
//   wr_en    : write wr_bit this cycle
//   wr_idx   : bit position to write
//   wr_bit   : serial bit from the chain
//   data     : captured word
// ---------------------------------------------------------------------------
module siso_deser
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic             wr_bit,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (wr_en) begin
      data[wr_idx] <= wr_bit;
    end
  end

endmodule

// File: rtl/siso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// siso_shift_ctrl
// Sequencing controller for an external serial-in/serial-out shift chain.
// Accepts a word, shifts it LSB-first into the chain (LOAD), shifts zeros
// until every bit has emerged (DRAIN), then presents the reassembled word
// (DONE). Because DRAIN pushes DEPTH zeros, the chain is all-zero whenever
// the controller returns to IDLE.
// Macro: SISO_CTRL_PARITY_EN appends an even-parity bit to each word and
// reports a mismatch on out_err.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : siso_shift_ctrl_if.slave (handshakes, chain control, status)
//   state_dbg : current FSM state
// ---------------------------------------------------------------------------
module siso_shift_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  siso_shift_ctrl_if.slave   bus,
  output state_t             state_dbg
);

  localparam int N  = WIDTH + PAR_BITS;
  localparam int CW = cnt_width(WIDTH, DEPTH);
  localparam int IW = idx_width(WIDTH);

  // Counter value == global shift cycle index.
  localparam logic [CW-1:0] LOAD_LAST = CW'(N - 1);
  localparam logic [CW-1:0] LAST      = CW'(N + DEPTH - 1);
  // Cycle c carries chain bit c-DEPTH on sh_so; only data bits are stored.
  localparam logic [CW-1:0] CAP_FIRST = CW'(DEPTH);
  localparam logic [CW-1:0] CAP_LAST  = CW'(DEPTH + WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     word_sr;
  logic [N-1:0]     load_word;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             sh_en_r;
  logic             sh_si_r;
  logic             busy_r;
  logic             cap_en;
  logic [IW-1:0]    cap_idx;
  logic [WIDTH-1:0] cap_data;

  // Word as it will be serialised: data bits, then the optional parity bit.
  always_comb begin
`ifdef SISO_CTRL_PARITY_EN
    load_word = {^bus.in_data, bus.in_data};
`else
    load_word = bus.in_data;
`endif
  end

  always_comb begin
    cap_en  = 1'b0;
    cap_idx = IW'(cnt - CAP_FIRST);
    if ((state == LOAD || state == DRAIN) &&
        (cnt >= CAP_FIRST) && (cnt <= CAP_LAST)) begin
      cap_en = 1'b1;
    end
  end

  siso_deser #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_deser (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (cap_en),
    .wr_idx (cap_idx),
    .wr_bit (bus.sh_so),
    .data   (cap_data)
  );

  // sh_si/sh_en are registered one cycle ahead: the value set on an edge is
  // what the chain shifts in on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word_sr     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sh_en_r     <= 1'b0;
      sh_si_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= LOAD;
            cnt        <= '0;
            word_sr    <= load_word >> 1;
            sh_si_r    <= load_word[0];
            sh_en_r    <= 1'b1;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt == LOAD_LAST) begin
            state   <= DRAIN;
            sh_si_r <= 1'b0;
          end else begin
            sh_si_r <= word_sr[0];
            word_sr <= word_sr >> 1;
          end
        end
        DRAIN: begin
          if (cnt == LAST) begin
            // Counter holds at its terminal value until the next accept.
            state       <= DONE;
            sh_en_r     <= 1'b0;
            sh_si_r     <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SISO_CTRL_PARITY_EN
  logic err_r;

  // The parity bit is the last one out of the chain; it is on sh_so during
  // the final DRAIN cycle while the data bits are already captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (state == DRAIN && cnt == LAST) begin
      err_r <= bus.sh_so ^ (^cap_data);
    end else if (state == DONE && bus.out_ready) begin
      err_r <= 1'b0;
    end
  end

  assign bus.out_err = err_r;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = cap_data;
  assign bus.sh_en     = sh_en_r;
  assign bus.sh_si     = sh_si_r;
  assign bus.busy      = busy_r;
  assign state_dbg     = state;

endmodule
